// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage feeding the processor control FSM.
// Reads 16-bit words from instruction memory at pc, buffers them in a small
// prefetch FIFO and hands one instruction at a time to the control FSM through
// ir_o/run_o, waiting for done_i before handing over the next one.
// Optional feature: define FETCH_HALT_EN to decode IR[15:13]==3'b111 as HALT.
module instr_fetch #(
    parameter int AW    = 8,
    parameter int DEPTH = 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic [AW-1:0] start_addr_i,
    input  logic          stop_i,
    output logic          mem_rd_o,
    output logic [AW-1:0] mem_addr_o,
    input  logic          mem_valid_i,
    input  logic [15:0]   mem_rdata_i,
    output logic [15:0]   ir_o,
    output logic          run_o,
    input  logic          done_i,
    output logic [AW-1:0] pc_o,
    output logic          busy_o,
    output logic          halted_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_e;

    state_e          state_q;
    logic [15:0]     fifo_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic [AW-1:0]   pc_q;
    logic [AW-1:0]   pc_d;
    logic [AW-1:0]   addr_q;
    logic            mem_rd_q;
    logic            drop_q;
    logic            enable_q;
    logic [15:0]     ir_q;
    logic            run_q;
    logic [15:0]     fifo_head;
    logic            pop;
    logic            push;
    logic            flush;
    logic            issue;
    logic            halt_take;

`ifdef FETCH_HALT_EN
    logic            halted_q;
`endif

    assign fifo_head = fifo_q[rd_ptr_q];

    // The FSM takes the head word whenever it is idle; a start in the same
    // cycle flushes the FIFO instead, so it blocks the pop.
    assign pop = (state_q == IDLE) && (count_q != '0) && !start_i;

`ifdef FETCH_HALT_EN
    assign halt_take = pop && (fifo_head[15:13] == 3'b111);
`else
    assign halt_take = 1'b0;
`endif

    assign flush = start_i || halt_take;

    // A response is dropped when it belongs to a read issued before a flush.
    assign push = mem_valid_i && mem_rd_q && !drop_q && !flush;

    // Credit rule: buffered words plus the outstanding read never exceed DEPTH.
    // Since at most one read is outstanding, !mem_rd_q folds that term away.
    assign issue = enable_q && !stop_i && !mem_rd_q && !flush
                   && (count_q < CW'(DEPTH));

    // Next FIFO occupancy and next program counter.
    always_comb begin
        count_d = count_q;
        pc_d    = pc_q;
        if (flush) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        if (start_i) begin
            pc_d = start_addr_i;
        end else if (issue) begin
            pc_d = pc_q + AW'(1);
        end
    end

    // Memory request side: one outstanding read, held until mem_valid_i.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q     <= '0;
            addr_q   <= '0;
            mem_rd_q <= 1'b0;
            drop_q   <= 1'b0;
            enable_q <= 1'b0;
        end else begin
            pc_q <= pc_d;
            if (start_i) begin
                enable_q <= 1'b1;
            end else if (stop_i || halt_take) begin
                enable_q <= 1'b0;
            end
            if (issue) begin
                mem_rd_q <= 1'b1;
                addr_q   <= pc_q;
            end else if (mem_rd_q && mem_valid_i) begin
                mem_rd_q <= 1'b0;
            end
            if (mem_rd_q && mem_valid_i) begin
                drop_q <= 1'b0;
            end else if (mem_rd_q && flush) begin
                drop_q <= 1'b1;
            end
        end
    end

    // FIFO pointers and occupancy; a flush empties it in one cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PW'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PW'(1);
                end
            end
        end
    end

    // FIFO storage; contents are only meaningful below count_q, so no reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= mem_rdata_i;
        end
    end

    // Issue FSM: hand one instruction over, then wait for the FSM's Done.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ir_q    <= '0;
            run_q   <= 1'b0;
`ifdef FETCH_HALT_EN
            halted_q <= 1'b0;
`endif
        end else begin
            run_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        ir_q <= fifo_head;
                        if (!halt_take) begin
                            run_q   <= 1'b1;
                            state_q <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (done_i) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
`ifdef FETCH_HALT_EN
            if (start_i) begin
                halted_q <= 1'b0;
            end else if (halt_take) begin
                halted_q <= 1'b1;
            end
`endif
        end
    end

    assign mem_rd_o   = mem_rd_q;
    assign mem_addr_o = addr_q;
    assign ir_o       = ir_q;
    assign run_o      = run_q;
    assign pc_o       = pc_q;
    assign busy_o     = (state_q != IDLE) || (count_q != '0) || mem_rd_q;

`ifdef FETCH_HALT_EN
    assign halted_o = halted_q;
`else
    assign halted_o = 1'b0;
`endif

endmodule
